// File: rtl/nibble_stream_tx.sv
// Nibble-serial word transmitter: sends nibbles 0..last_idx of a captured 32-bit word, LSB- or MSB-first.
// Optional NIBBLE_STREAM_TX_BACK2BACK_EN accepts the next word on the final nibble handshake (no idle gap).
module nibble_stream_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [31:0] word,
    input  logic        msb_first,
    input  logic [2:0]  last_idx,
    output logic        nib_valid,
    input  logic        nib_ready,
    output logic [3:0]  nib,
    output logic [2:0]  nib_idx,
    output logic        nib_last,
    output logic        busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_nxt;
    logic [31:0] word_q;
    logic        msb_q;
    logic [2:0]  last_q;
    logic [2:0]  cnt, cnt_nxt;
    logic        load;
    logic        at_term;

    assign at_term = (cnt == (msb_q ? 3'd0 : last_q));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        word_ready = 1'b0;
        nib_valid  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                word_ready = !rst;
                if (word_valid && !rst) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                nib_valid = 1'b1;
                if (nib_ready) begin
                    if (at_term) begin
`ifdef NIBBLE_STREAM_TX_BACK2BACK_EN
                        word_ready = !rst;
                        if (word_valid && !rst) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        cnt_nxt = msb_q ? cnt - 3'd1 : cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            cnt_nxt = msb_first ? last_idx : 3'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            word_q <= 32'd0;
            msb_q  <= 1'b0;
            last_q <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                word_q <= word;
                msb_q  <= msb_first;
                last_q <= last_idx;
            end
        end
    end

    // Nibble outputs read as zero outside SEND so idle and reset look identical downstream.
    assign busy     = (state == SEND);
    assign nib      = busy ? word_q[{cnt, 2'b00} +: 4] : 4'd0;
    assign nib_idx  = busy ? cnt : 3'd0;
    assign nib_last = busy && at_term;

endmodule

// File: tb/tb_nibble_stream_tx.sv
// Directed bench for nibble_stream_tx: vector table of whole words plus hand-written
// backpressure, mid-stream reset and back-to-back sequences.
module tb_nibble_stream_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word;
    logic        msb_first;
    logic [2:0]  last_idx;
    logic        nib_valid;
    logic        nib_ready;
    logic [3:0]  nib;
    logic [2:0]  nib_idx;
    logic        nib_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    nibble_stream_tx dut (
        .clk        (clk),
        .rst        (rst),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word       (word),
        .msb_first  (msb_first),
        .last_idx   (last_idx),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .nib        (nib),
        .nib_idx    (nib_idx),
        .nib_last   (nib_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // exp_nib / exp_idx hold the expected nibbles and indices in emission order, element 0 lowest.
    typedef struct {
        logic [31:0] word;
        logic        msb;
        logic [2:0]  last;
        int          cnt;
        logic [31:0] exp_nib;
        logic [23:0] exp_idx;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left just after a rising edge with the block idle; nib_ready held high.
    task automatic send_word(input vec_t v);
        logic exp_wr;
        word_valid = 1'b1;
        word       = v.word;
        msb_first  = v.msb;
        last_idx   = v.last;
        nib_ready  = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(word_ready), 32'd1);
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        word       = ~v.word;
        msb_first  = ~v.msb;
        last_idx   = ~v.last;
        for (int i = 0; i < v.cnt; i++) begin
            @(negedge clk);
`ifdef NIBBLE_STREAM_TX_BACK2BACK_EN
            exp_wr = (i == v.cnt - 1);
`else
            exp_wr = 1'b0;
`endif
            check("nib_valid", 32'(nib_valid), 32'd1);
            check("nib", 32'(nib), 32'(v.exp_nib[4*i +: 4]));
            check("nib_idx", 32'(nib_idx), 32'(v.exp_idx[3*i +: 3]));
            check("nib_last", 32'(nib_last), 32'(i == v.cnt - 1));
            check("busy", 32'(busy), 32'd1);
            check("send_word_ready", 32'(word_ready), 32'(exp_wr));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("end_nib_valid", 32'(nib_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_word_ready", 32'(word_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] bp_pat;
        int         e;
        int         acc;
        logic       exp_v;
        logic [3:0] exp_n;

        vecs[0] = '{32'h0F00_1234, 1'b0, 3'd7, 8, 32'h0F00_1234, 24'o76543210};
        vecs[1] = '{32'h0600_0000, 1'b1, 3'd7, 8, 32'h0000_0060, 24'o01234567};
        vecs[2] = '{32'hABCD_E123, 1'b0, 3'd2, 3, 32'h0000_0123, 24'o210};
        vecs[3] = '{32'hABCD_E123, 1'b1, 3'd0, 1, 32'h0000_0003, 24'o0};
        vecs[4] = '{32'h8765_4321, 1'b1, 3'd3, 4, 32'h0000_1234, 24'o0123};
        vecs[5] = '{32'h0000_0005, 1'b0, 3'd1, 2, 32'h0000_0005, 24'o10};

        rst        = 1'b1;
        word_valid = 1'b1;
        word       = 32'hDEAD_BEEF;
        msb_first  = 1'b0;
        last_idx   = 3'd7;
        nib_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_word_ready", 32'(word_ready), 32'd0);
        check("rst_nib_valid", 32'(nib_valid), 32'd0);
        check("rst_nib", 32'(nib), 32'd0);
        check("rst_nib_idx", 32'(nib_idx), 32'd0);
        check("rst_nib_last", 32'(nib_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        check("post_rst_word_ready", 32'(word_ready), 32'd1);
        check("post_rst_nib_valid", 32'(nib_valid), 32'd0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) send_word(vecs[v]);

        // Backpressure: outputs must hold while nib_ready is low.
        bp_pat     = 10'b11111_01001;   // bit c = nib_ready in cycle c: 1,0,0,1,0,1,1,1,1,1
        word_valid = 1'b1;
        word       = 32'h8765_4321;
        msb_first  = 1'b0;
        last_idx   = 3'd7;
        nib_ready  = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        word       = 32'h0;
        e = 0;
        for (int c = 0; c < 24 && e < 8; c++) begin
            nib_ready = (c < 10) ? bp_pat[c] : 1'b1;
            @(negedge clk);
            check("bp_nib_valid", 32'(nib_valid), 32'd1);
            check("bp_nib", 32'(nib), 32'(e + 1));
            check("bp_nib_idx", 32'(nib_idx), 32'(e));
            check("bp_nib_last", 32'(nib_last), 32'(e == 7));
            @(posedge clk);
            if (nib_ready) e++;
            #1;
        end
        check("bp_nibbles_consumed", 32'(e), 32'd8);
        nib_ready = 1'b1;
        @(negedge clk);
        check("bp_end_nib_valid", 32'(nib_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset after three nibbles of an all-ones word.
        word_valid = 1'b1;
        word       = 32'hFFFF_FFFF;
        msb_first  = 1'b0;
        last_idx   = 3'd7;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b1;
        word_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_word_ready", 32'(word_ready), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        check("after_rst_nib_valid", 32'(nib_valid), 32'd0);
        check("after_rst_busy", 32'(busy), 32'd0);
        check("after_rst_word_ready", 32'(word_ready), 32'd1);
        @(posedge clk);
        #1;
        send_word(vecs[5]);

        // Back-to-back words with word_valid held.
        word_valid = 1'b1;
        word       = 32'h1111_1111;
        msb_first  = 1'b0;
        last_idx   = 3'd7;
        nib_ready  = 1'b1;
        @(negedge clk);
        check("b2b_first_ready", 32'(word_ready), 32'd1);
        @(posedge clk);
        #1;
        word = 32'h2222_2222;
        acc  = 1;
        for (int c = 0; c < 18; c++) begin
`ifdef NIBBLE_STREAM_TX_BACK2BACK_EN
            exp_v = (c < 16);
            exp_n = (c < 8) ? 4'd1 : ((c < 16) ? 4'd2 : 4'd0);
`else
            exp_v = (c != 8) && (c < 17);
            exp_n = (c < 8) ? 4'd1 : ((c >= 9 && c < 17) ? 4'd2 : 4'd0);
`endif
            @(negedge clk);
            check("b2b_nib_valid", 32'(nib_valid), 32'(exp_v));
            check("b2b_nib", 32'(nib), 32'(exp_n));
            @(posedge clk);
            if (word_valid && word_ready) acc++;
            #1;
            if (acc >= 2) word_valid = 1'b0;
        end
        check("b2b_words_accepted", 32'(acc), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/nibble_stream_tx.md
# nibble_stream_tx

Nibble-serial word transmitter: accepts a 32-bit word and emits it as a stream of 4-bit nibbles, one per handshake, either LSB-first or MSB-first, over a configurable number of nibbles. It is the sending end of the nibble-serial datapath. It feeds the nibble-wide ALU loop and nibble-wide links from word-wide registers, using the same nibble indexing (0..7) and the same direction convention: MSB-first for right shifts.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- word_valid  in  1  word offered
- word_ready  out  1  block can accept a word
- word  in  32  word to send, viewed as 8 nibbles, nibble i = word[4i+3:4i]
- msb_first  in  1  1: send from nibble last_idx down to 0; 0: send 0 up to last_idx
- last_idx  in  3  index of highest nibble to send; nibble count = last_idx+1
- nib_valid  out  1  nibble on nib is valid
- nib_ready  in  1  downstream consumes nibble
- nib  out  4  current nibble
- nib_idx  out  3  index of current nibble within word
- nib_last  out  1  current nibble is the final one of the word
- busy  out  1  word in flight (state SEND)

## Operation
- FSM states: IDLE, SEND.
- word, msb_first and last_idx are sampled only on the word handshake (word_valid && word_ready), into internal registers. Later changes to these inputs have no effect on the word in flight.
- IDLE:
  - word_ready=1, nib_valid=0.
  - On word handshake: capture inputs; counter <= msb_first ? last_idx : 0; go to SEND.
- SEND:
  - word_ready=0, nib_valid=1.
  - nib = captured nibble[counter]; nib_idx = counter.
  - nib_last = (counter == terminal), where terminal = captured msb_first ? 0 : captured last_idx.
- Nibble handshake (nib_valid && nib_ready):
  - If not nib_last: counter steps toward terminal (−1 if MSB-first, +1 otherwise).
  - If nib_last: go to IDLE.
- Counter is 3 bits and never wraps: the step is suppressed at terminal.
- last_idx=0: exactly one nibble, nib_last=1 on it, in either direction.
- Nibbles above last_idx are never emitted.
- Backpressure: while nib_valid && !nib_ready, nib, nib_idx and nib_last hold stable.
- busy = (state == SEND).

## Timing
- While rst is high, and on the cycle after it, the block is in IDLE with:
  - word_ready=0 during rst, 1 from the first cycle with rst low
  - nib_valid=0, nib=0, nib_idx=0, nib_last=0, busy=0
  - captured word=0, counter=0
- Word handshake in cycle N gives nib_valid=1 in cycle N+1 (latency 1).
- With nib_ready held high:
  - k = last_idx+1 consecutive nibble cycles.
  - Back in IDLE the cycle after the last nibble, so one word costs k+1 cycles.
- Reset mid-SEND: the word in flight is dropped and no further nibbles are emitted. The next cycle has nib_valid=0 and busy=0. A subsequent word starts from its first index.
- rst has priority over every simultaneous handshake.

## Configuration
- NIBBLE_STREAM_TX_BACK2BACK_EN
  - Defined:
    - In SEND, word_ready = nib_last && nib_ready.
    - A word handshake coinciding with the final nibble handshake loads the new word and stays in SEND, so the next word's first nibble appears in the following cycle with no gap.
    - Sustained throughput: k cycles per word.
  - Undefined: word_ready=0 throughout SEND, giving one idle cycle between words.

## Test plan
- LSB-first, last_idx=7, word=0x0F00_1234, nib_ready=1:
  - nibbles 4,3,2,1,0,0,F,0 with nib_idx 0..7
  - nib_last only on the 8th nibble
  - busy high for 8 cycles, word_ready low for the same 8 cycles
- MSB-first, last_idx=7, word=0x0600_0000: nibbles 0,6,0,0,0,0,0,0 with nib_idx 7..0; nib_last at nib_idx=0.
- Partial word:
  - LSB-first, last_idx=2, word=0xABCD_E123: nibbles 3,2,1, nib_last on the 3rd, then IDLE.
  - MSB-first, last_idx=0, same word: single nibble 3 with nib_last=1.
- Backpressure: nib_ready pattern 1,0,0,1,0,1,1,1,1,1 on 0x8765_4321 LSB-first. Outputs hold during low cycles; exactly nibbles 1..8 in order, none skipped or duplicated.
- Reset mid-stream:
  - Assert rst after 3 nibbles of 0xFFFF_FFFF. The next cycle shows nib_valid=0, busy=0.
  - After rst deasserts, word_ready=1; word 0x0000_0005 LSB-first last_idx=1 yields 5,0.
- Back-to-back: word_valid held with words 0x1111_1111 then 0x2222_2222, last_idx=7, nib_ready=1.
  - With NIBBLE_STREAM_TX_BACK2BACK_EN: 16 consecutive nib_valid cycles.
  - Without it: a one-cycle nib_valid=0 gap between the two words.
